// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared defaults, FSM encoding and small helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 4;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Index increment that wraps at n, used to advance the round-robin pointer.
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);

    int            cand_s;
    logic [IW-1:0] cand_idx_s;

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        valid      = 1'b0;
        index      = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_s = int'(rr_ptr) + i;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IW'(cand_s);
            if (req[cand_idx_s]) begin
                valid = 1'b1;
                index = cand_idx_s;
            end else begin
                valid = valid;
                index = index;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NREQ write-domain requesters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    last,
    input  logic [NREQ*DW-1:0] data,
    input  logic               wfull,
    output logic               winc,
    output logic [DW-1:0]      wdata,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    output logic               busy
);

    localparam int            IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_e                      state_r;
    state_e                      state_next_s;
    logic [IW-1:0]               owner_r;
    logic [IW-1:0]               rr_ptr_r;
    logic [3:0]                  beat_cnt_r;
    logic [NREQ-1:0]             gnt_r;
    logic                        busy_r;

    logic                        pick_valid_s;
    logic [IW-1:0]               pick_idx_s;
    logic [NREQ-1:0][DW-1:0]     data_a_s;
    logic                        owner_req_s;
    logic                        owner_last_s;
    logic [DW-1:0]               owner_data_s;
    logic                        fire_s;
    logic                        cap_s;
    logic                        end_s;

    assign data_a_s = data;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .valid  (pick_valid_s),
        .index  (pick_idx_s)
    );

    // Owner view of the request bus; a withdrawal ends the burst without a beat.
    always_comb begin
        owner_req_s  = req[owner_r];
        owner_last_s = last[owner_r];
        owner_data_s = data_a_s[owner_r];
        fire_s       = (state_r == BURST) && owner_req_s && !wfull;
        cap_s        = (beat_cnt_r == 4'(MAX_BURST - 1));
        end_s        = (state_r == BURST) &&
                       (!owner_req_s || (fire_s && (owner_last_s || cap_s)));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = BURST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                if (end_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BURST;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Owner, pointer, beat counter and the registered grant/busy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= 4'd0;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        owner_r    <= pick_idx_s;
                        beat_cnt_r <= 4'd0;
                        gnt_r      <= ONE << pick_idx_s;
                        busy_r     <= 1'b1;
                    end
                end
                BURST: begin
                    if (end_s) begin
                        rr_ptr_r   <= IW'(wrap_inc(int'(owner_r), NREQ));
                        beat_cnt_r <= 4'd0;
                        gnt_r      <= '0;
                        busy_r     <= 1'b0;
                    end else if (fire_s) begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                    end
                end
                default: begin
                    gnt_r  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe, ack and data mux follow the beat condition in the same cycle.
    always_comb begin
        winc  = fire_s;
        ack   = '0;
        wdata = '0;
        if (fire_s) begin
            ack   = ONE << owner_r;
            wdata = owner_data_s;
        end else begin
            ack   = '0;
            wdata = '0;
        end
    end

    assign gnt  = gnt_r;
    assign busy = busy_r;

endmodule
